// File: rtl/cl_reader_pkg.sv
// cl_reader_pkg: state encoding, output latency and counter sizing shared by the
// CameraLink FIFO reader.
package cl_reader_pkg;
  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;
  localparam int OUT_LAT = 2;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/cl_fifo_reader.sv
// cl_fifo_reader: drains the pixel FIFO read port and regenerates CameraLink
// FVAL/LVAL/DVAL timing, absorbing underflow as skipped slots.
module cl_fifo_reader
  import cl_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int H_ACTIVE = 1024,
  parameter int H_BLANK = 64,
  parameter int V_ACTIVE = 768,
  parameter int V_BLANK = 4,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              fifo_almost_empty,
  output logic              cl_fval,
  output logic              cl_lval,
  output logic              cl_dval,
  output logic [DATA_W-1:0] cl_data,
  output logic              underflow,
  output logic [15:0]       err_cnt,
  input  logic              err_clr,
  output logic              busy
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int VB_CYC = V_BLANK * H_TOTAL;
  localparam int PIX_W = cnt_w(H_ACTIVE > H_BLANK ? H_ACTIVE : H_BLANK);
  localparam int LINE_W = cnt_w(V_ACTIVE);
  localparam int VB_W = cnt_w(VB_CYC);
  localparam logic [PIX_W-1:0] PIX_LAST_A = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0] PIX_LAST_B = PIX_W'(H_BLANK - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [VB_W-1:0] VB_LAST = VB_W'(VB_CYC - 1);

  state_t state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [VB_W-1:0] vb_cnt_q, vb_cnt_d;
  logic start, pix_last, line_last, vb_last, slot;
  logic [OUT_LAT-1:0] fval_q, fval_d, lval_q, lval_d;
  logic slot_q, slot_d, hit_q, hit_d;
  logic dval_q, dval_d, uf_q, uf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0] err_q, err_d;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    start = en & ~fifo_almost_empty;
    pix_last = pix_cnt_q == (state_q == LINE ? PIX_LAST_A : PIX_LAST_B);
    line_last = line_cnt_q == LINE_LAST;
    vb_last = vb_cnt_q == VB_LAST;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LINE : IDLE;
      LINE:    state_d = pix_last ? HBLANK : LINE;
      HBLANK:  state_d = pix_last ? (line_last ? VBLANK : LINE) : HBLANK;
      default: state_d = vb_last ? (start ? LINE : IDLE) : VBLANK;
    endcase
    pix_cnt_d = (state_q inside {LINE, HBLANK}) && !pix_last ? pix_cnt_q + 1'b1 : '0;
    line_cnt_d = (state_q == HBLANK && pix_last) ? (line_last ? '0 : line_cnt_q + 1'b1) : line_cnt_q;
    vb_cnt_d = (state_q == VBLANK && !vb_last) ? vb_cnt_q + 1'b1 : '0;
  end

  // Stage 1 tracks the slot and whether it issued a read; stage 2 meets the
  // returning FIFO data, so timing flags ride a matching two-deep pipe.
  always_comb begin
    slot = state_q == LINE;
    fifo_rd_en = slot & ~fifo_rd_empty;
    busy = state_q != IDLE;
    slot_d = slot;
    hit_d = fifo_rd_en;
    fval_d = {fval_q[OUT_LAT-2:0], state_q inside {LINE, HBLANK}};
    lval_d = {lval_q[OUT_LAT-2:0], slot};
    data_d = hit_q ? fifo_rd_data : FILL;
    dval_d = hit_q;
    uf_d = slot_q & ~hit_q;
    err_d = err_clr ? '0 : (uf_q && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    cl_fval = fval_q[OUT_LAT-1];
    cl_lval = lval_q[OUT_LAT-1];
    cl_dval = dval_q;
    cl_data = data_q;
    underflow = uf_q;
    err_cnt = err_q;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pix_cnt_q <= '0;
      line_cnt_q <= '0;
      vb_cnt_q <= '0;
      fval_q <= '0;
      lval_q <= '0;
      slot_q <= 1'b0;
      hit_q <= 1'b0;
      dval_q <= 1'b0;
      uf_q <= 1'b0;
      data_q <= '0;
      err_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      vb_cnt_q <= vb_cnt_d;
      fval_q <= fval_d;
      lval_q <= lval_d;
      slot_q <= slot_d;
      hit_q <= hit_d;
      dval_q <= dval_d;
      uf_q <= uf_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_cl_fifo_reader.sv
// tb_cl_fifo_reader: scoreboard bench with a queue-based FIFO/frame model, plus a
// second always-starved instance that drives err_cnt into saturation.
module tb_cl_fifo_reader;
  localparam int HA = 4, HB = 2, VA = 3, VB = 1;
  localparam int HT = HA + HB, FRAME = (VA + VB) * HT, SLOTS = VA * HA;

  typedef struct packed {logic [7:0] d; logic v;} slot_t;

  logic clk = 0, rst_n = 0, en = 0, err_clr = 0;
  logic fifo_rd_en, fifo_rd_empty = 1, fifo_almost_empty = 1;
  logic [7:0] fifo_rd_data = 0, cl_data;
  logic cl_fval, cl_lval, cl_dval, underflow, busy;
  logic [15:0] err_cnt;
  logic s_rst_n = 0, s_fifo_rd_en, s_cl_fval, s_cl_lval, s_cl_dval, s_underflow, s_busy;
  logic [7:0] s_cl_data;
  logic [15:0] s_err_cnt;

  int total = 0, bad = 0, cyc = 0;
  int wr_ptr = 0, rd_ptr = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] model_q[$];
  slot_t sb[$];
  int lrise[$], llen[$], frise[$], flen[$];
  int lrun = 0, frun = 0, exp_err = 0;
  bit uf_pend = 0, sat_done = 0;

  always #5 clk = ~clk;

  cl_fifo_reader #(.DATA_W(8), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .FILL(8'h00)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .en(en), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty), .cl_fval(cl_fval),
    .cl_lval(cl_lval), .cl_dval(cl_dval), .cl_data(cl_data), .underflow(underflow),
    .err_cnt(err_cnt), .err_clr(err_clr), .busy(busy));

  cl_fifo_reader #(.DATA_W(8), .H_ACTIVE(128), .H_BLANK(1), .V_ACTIVE(128), .V_BLANK(1), .FILL(8'h00)) dut_sat (
    .rd_clk(clk), .rd_rst_n(s_rst_n), .en(1'b1), .fifo_rd_en(s_fifo_rd_en), .fifo_rd_data(8'h00),
    .fifo_rd_empty(1'b1), .fifo_almost_empty(1'b0), .cl_fval(s_cl_fval),
    .cl_lval(s_cl_lval), .cl_dval(s_cl_dval), .cl_data(s_cl_data), .underflow(s_underflow),
    .err_cnt(s_err_cnt), .err_clr(1'b0), .busy(s_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read port: data appears the cycle after a granted read
  always @(posedge clk) begin
    int p;
    p = (fifo_rd_en && wr_ptr != rd_ptr) ? 1 : 0;
    if (p == 1) fifo_rd_data <= mem[rd_ptr % 1024];
    rd_ptr <= rd_ptr + p;
    fifo_rd_empty <= (wr_ptr - rd_ptr - p) == 0;
    fifo_almost_empty <= (wr_ptr - rd_ptr - p) <= 1;
  end

  always @(negedge clk) begin
    slot_t it;
    if (!rst_n) begin
      lrun = 0;
      frun = 0;
      uf_pend = 0;
    end else begin
      chk("err_cnt_track", err_cnt, exp_err);
      chk("rd_en_while_empty", fifo_rd_en & fifo_rd_empty, 0);
      uf_pend = 0;
      if (cl_lval) begin
        chk("fval_during_lval", cl_fval, 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty actual=lval required=no_slot (cycle %0d)", cyc);
        end else begin
          it = sb.pop_front();
          chk("slot_data", cl_data, it.d);
          chk("slot_dval", cl_dval, it.v);
          chk("slot_underflow", underflow, !it.v);
          uf_pend = !it.v;
        end
        if (lrun == 0) lrise.push_back(cyc);
        lrun++;
      end else begin
        chk("quiet_dval_uf", {cl_dval, underflow}, 0);
        if (lrun > 0) llen.push_back(lrun);
        lrun = 0;
      end
      if (cl_fval) begin
        if (frun == 0) frise.push_back(cyc);
        frun++;
      end else begin
        if (frun > 0) flen.push_back(frun);
        frun = 0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_err = 0;
    else if (err_clr) exp_err = 0;
    else if (uf_pend && exp_err < 65535) exp_err++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load(input int n, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      mem[wr_ptr % 1024] = v;
      wr_ptr++;
      model_q.push_back(v);
    end
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    model_q.delete();
  endtask

  // Each slot consumes the oldest word if one is left, else it is an underflow
  task automatic expect_frames(input int nf);
    slot_t s;
    for (int i = 0; i < nf * SLOTS; i++) begin
      if (model_q.size() > 0) begin
        s.d = model_q.pop_front();
        s.v = 1;
      end else begin
        s.d = 8'h00;
        s.v = 0;
      end
      sb.push_back(s);
    end
  endtask

  task automatic start(output int t0, input bit hold);
    en = 1;
    t0 = cyc;
    tick();
    chk("start_rd_en", fifo_rd_en, 1);
    chk("start_busy", busy, 1);
    if (!hold) en = 0;
  endtask

  task automatic wait_idle(input int t0, input int nf);
    go_to(t0 + nf * FRAME);
    chk("busy_last_cycle", busy, 1);
    tick();
    chk("idle_after_frame", busy, 0);
    chk("fval_after_frame", cl_fval, 0);
  endtask

  task automatic check_timing(input int t0, input int nf);
    chk("lval_bursts", lrise.size(), nf * VA);
    for (int i = 0; i < nf * VA && lrise.size() > 0 && llen.size() > 0; i++) begin
      chk("lval_rise", lrise.pop_front(), t0 + 3 + (i / VA) * FRAME + (i % VA) * HT);
      chk("lval_len", llen.pop_front(), HA);
    end
    chk("fval_frames", frise.size(), nf);
    for (int i = 0; i < nf && frise.size() > 0 && flen.size() > 0; i++) begin
      chk("fval_rise", frise.pop_front(), t0 + 3 + i * FRAME);
      chk("fval_len", flen.pop_front(), VA * HT);
    end
    chk("sb_drained", sb.size(), 0);
    lrise.delete();
    llen.delete();
    frise.delete();
    flen.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1;
    go_to(16600);
    chk("sat_one_frame", s_err_cnt, 16384);
    go_to(68000);
    chk("sat_ffff", s_err_cnt, 16'hFFFF);
    chk("sat_no_read", s_fifo_rd_en, 0);
    go_to(69000);
    chk("sat_hold", s_err_cnt, 16'hFFFF);
    chk("sat_busy", s_busy, 1);
    sat_done = 1;
  end

  initial begin
    int t0, n;
    bit seen;
    #1;
    chk("rst_outs", {cl_fval, cl_lval, cl_dval, underflow, fifo_rd_en, busy}, 0);
    chk("rst_data_err", {cl_data, err_cnt}, 0);
    tick(2);
    rst_n = 1;
    repeat (10) begin
      tick();
      chk("idle_outs", {cl_fval, cl_lval, cl_dval, underflow, fifo_rd_en, busy}, 0);
      chk("idle_data_err", {cl_data, err_cnt}, 0);
    end

    load(12, 0);
    expect_frames(1);
    tick();
    start(t0, 0);
    wait_idle(t0, 1);
    check_timing(t0, 1);
    chk("single_err", err_cnt, 0);

    load(5, 0);
    expect_frames(1);
    tick();
    start(t0, 0);
    go_to(t0 + 14);
    chk("uf_err_line2", err_cnt, 3);
    wait_idle(t0, 1);
    check_timing(t0, 1);
    chk("uf_err_end", err_cnt, 7);

    err_clr = 1;
    tick();
    err_clr = 0;
    chk("err_clear", err_cnt, 0);

    load(48, 0);
    expect_frames(2);
    tick();
    start(t0, 1);
    go_to(t0 + FRAME + 8);
    en = 0;
    wait_idle(t0, 2);
    check_timing(t0, 2);
    flush();

    load(11, 0);
    expect_frames(1);
    tick();
    start(t0, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (underflow) begin
        seen = 1;
        break;
      end
    end
    chk("uf_pulse_seen", seen, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_beats_uf", err_cnt, 0);
    wait_idle(t0, 1);
    check_timing(t0, 1);

    repeat (4) begin
      n = $urandom_range(2, 14);
      load(n, 1);
      expect_frames(1);
      tick();
      start(t0, 0);
      wait_idle(t0, 1);
      check_timing(t0, 1);
      flush();
    end

    load(12, 0);
    expect_frames(1);
    tick();
    start(t0, 0);
    go_to(t0 + 9);
    chk("pre_rst_lval", cl_lval, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_outs", {cl_fval, cl_lval, cl_dval, underflow, fifo_rd_en, busy}, 0);
    chk("midrst_data_err", {cl_data, err_cnt}, 0);
    tick(2);
    rst_n = 1;
    flush();
    sb.delete();
    lrise.delete();
    llen.delete();
    frise.delete();
    flen.delete();
    tick(3);
    chk("post_rst_idle", {busy, cl_fval, fifo_rd_en}, 0);

    wait (sat_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
